// File: rtl/vdp_pkg.sv
// Shared types and constants for the CPU-side VDP access path.
package vdp_pkg;

  typedef enum logic [1:0] {
    CODE_VRAM_RD = 2'd0,
    CODE_VRAM_WR = 2'd1,
    CODE_REG_WR  = 2'd2,
    CODE_CRAM_WR = 2'd3
  } vdp_code_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_REQ
  } vdp_state_t;

  localparam logic [7:0] VDP_CTRL_PORT = 8'hBF;
  localparam logic [7:0] VDP_DATA_PORT = 8'hBE;

endpackage

// File: rtl/vdp_cmd_latch.sv
// Two-byte control word assembly: first-byte flag, VRAM address register
// with wrapping auto-increment, and access code register.
module vdp_cmd_latch
  import vdp_pkg::*;
#(
  parameter int unsigned VRAM_AW = 14
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               ctrl_wr,
  input  logic               clr_first,
  input  logic               addr_inc,
  input  logic [7:0]         wdata,
  output logic [VRAM_AW-1:0] addr,
  output vdp_code_t          code,
  output logic               first_flag,
  output logic               second_byte
);

  assign second_byte = ctrl_wr && first_flag;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      addr       <= '0;
      code       <= CODE_VRAM_RD;
      first_flag <= 1'b0;
    end else if (ctrl_wr) begin
      if (!first_flag) begin
        addr[7:0]  <= wdata;
        first_flag <= 1'b1;
      end else begin
        addr[VRAM_AW-1:8] <= wdata[VRAM_AW-9:0];
        code              <= vdp_code_t'(wdata[7:6]);
        first_flag        <= 1'b0;
      end
    end else begin
      if (clr_first) begin
        first_flag <= 1'b0;
      end
      // Natural overflow of the register gives the modulo-2^VRAM_AW wrap.
      if (addr_inc) begin
        addr <= addr + VRAM_AW'(1);
      end
    end
  end

endmodule

// File: rtl/vdp_access_ctrl.sv
// CPU-side VDP access sequencer: VRAM prefetch/write FSM, CRAM and register writes.
// Optional macro VDP_ACCESS_OVERRUN_EN adds a sticky 'overrun' flag for dropped strobes.
module vdp_access_ctrl
  import vdp_pkg::*;
#(
  parameter int unsigned VRAM_AW = 14,
  parameter int unsigned CRAM_AW = 5,
  parameter int unsigned REG_AW  = 4
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               cpu_wr_stb,
  input  logic               cpu_rd_stb,
  input  logic               cpu_port_sel,
  input  logic [7:0]         cpu_wdata,
  output logic [7:0]         cpu_rdata,
  output logic               cpu_wait,
  output logic               vram_req,
  output logic               vram_we,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [7:0]         vram_wdata,
  input  logic               vram_gnt,
  input  logic [7:0]         vram_rdata,
  output logic               cram_we,
  output logic [CRAM_AW-1:0] cram_addr,
  output logic [7:0]         cram_wdata,
  output logic               reg_we,
  output logic [REG_AW-1:0]  reg_addr,
  output logic [7:0]         reg_wdata
`ifdef VDP_ACCESS_OVERRUN_EN
  ,
  output logic               overrun
`endif
);

  vdp_state_t         state_q, state_d;
  logic [7:0]         rd_buf_q;
  logic [7:0]         wdata_q;
  logic               cram_we_q;
  logic [CRAM_AW-1:0] cram_addr_q;
  logic [7:0]         cram_wdata_q;
  logic               reg_we_q;
  logic [REG_AW-1:0]  reg_addr_q;
  logic [7:0]         reg_wdata_q;

  logic               busy;
  logic               wr_acc, rd_acc;
  logic               ctrl_wr, data_wr, ctrl_rd, data_rd;
  logic               cram_hit, reg_hit, prefetch_hit;
  logic               clr_first, addr_inc;
  logic [VRAM_AW-1:0] addr;
  vdp_code_t          code;
  logic               first_flag;
  logic               second_byte;

  assign busy = (state_q != IDLE);

  // Strobes are only accepted while idle; a write strobe masks a coincident read.
  assign wr_acc  = cpu_wr_stb && !busy;
  assign rd_acc  = cpu_rd_stb && !cpu_wr_stb && !busy;
  assign ctrl_wr = wr_acc && cpu_port_sel;
  assign data_wr = wr_acc && !cpu_port_sel;
  assign ctrl_rd = rd_acc && cpu_port_sel;
  assign data_rd = rd_acc && !cpu_port_sel;

  assign clr_first    = data_wr || data_rd || ctrl_rd;
  assign cram_hit     = data_wr && (code == CODE_CRAM_WR);
  assign reg_hit      = second_byte && (cpu_wdata[7:6] == CODE_REG_WR);
  assign prefetch_hit = second_byte && (cpu_wdata[7:6] == CODE_VRAM_RD);
  assign addr_inc     = cram_hit || ((state_q == WR_REQ) && vram_gnt) || (state_q == RD_DATA);

  vdp_cmd_latch #(
    .VRAM_AW(VRAM_AW)
  ) u_cmd_latch (
    .clk        (clk),
    .reset_L    (reset_L),
    .ctrl_wr    (ctrl_wr),
    .clr_first  (clr_first),
    .addr_inc   (addr_inc),
    .wdata      (cpu_wdata),
    .addr       (addr),
    .code       (code),
    .first_flag (first_flag),
    .second_byte(second_byte)
  );

  always_comb begin
    state_d  = state_q;
    vram_req = 1'b0;
    vram_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_wr && !cram_hit) begin
          state_d = WR_REQ;
        end else if (data_rd || prefetch_hit) begin
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        vram_req = 1'b1;
        if (vram_gnt) begin
          state_d = RD_DATA;
        end
      end
      RD_DATA: state_d = IDLE;
      WR_REQ: begin
        vram_req = 1'b1;
        vram_we  = 1'b1;
        if (vram_gnt) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= IDLE;
      rd_buf_q     <= '0;
      wdata_q      <= '0;
      cram_we_q    <= 1'b0;
      cram_addr_q  <= '0;
      cram_wdata_q <= '0;
      reg_we_q     <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cram_we_q <= cram_hit;
      reg_we_q  <= reg_hit;
      if (data_wr) begin
        rd_buf_q <= cpu_wdata;
        wdata_q  <= cpu_wdata;
      end else if (state_q == RD_DATA) begin
        rd_buf_q <= vram_rdata;
      end
      if (cram_hit) begin
        cram_addr_q  <= addr[CRAM_AW-1:0];
        cram_wdata_q <= cpu_wdata;
      end
      // The first control byte still sits in addr[7:0] and is the register value.
      if (reg_hit) begin
        reg_addr_q  <= cpu_wdata[REG_AW-1:0];
        reg_wdata_q <= addr[7:0];
      end
    end
  end

  assign cpu_rdata  = rd_buf_q;
  assign cpu_wait   = busy;
  assign vram_addr  = addr;
  assign vram_wdata = wdata_q;
  assign cram_we    = cram_we_q;
  assign cram_addr  = cram_addr_q;
  assign cram_wdata = cram_wdata_q;
  assign reg_we     = reg_we_q;
  assign reg_addr   = reg_addr_q;
  assign reg_wdata  = reg_wdata_q;

`ifdef VDP_ACCESS_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      overrun_q <= 1'b0;
    end else if (ctrl_rd) begin
      overrun_q <= 1'b0;
    end else if ((cpu_wr_stb || cpu_rd_stb) && busy) begin
      overrun_q <= 1'b1;
    end
  end

  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_vdp_access_ctrl.sv
// Directed self-checking bench for vdp_access_ctrl (default parameters).
module tb_vdp_access_ctrl;

  logic        clk;
  logic        reset_L;
  logic        cpu_wr_stb;
  logic        cpu_rd_stb;
  logic        cpu_port_sel;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_wait;
  logic        vram_req;
  logic        vram_we;
  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_gnt;
  logic [7:0]  vram_rdata;
  logic        cram_we;
  logic [4:0]  cram_addr;
  logic [7:0]  cram_wdata;
  logic        reg_we;
  logic [3:0]  reg_addr;
  logic [7:0]  reg_wdata;
`ifdef VDP_ACCESS_OVERRUN_EN
  logic        overrun;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int req_cycles = 0;
  int reg_pulses = 0;
  int req_mark;

  vdp_access_ctrl dut (
    .clk         (clk),
    .reset_L     (reset_L),
    .cpu_wr_stb  (cpu_wr_stb),
    .cpu_rd_stb  (cpu_rd_stb),
    .cpu_port_sel(cpu_port_sel),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_wait    (cpu_wait),
    .vram_req    (vram_req),
    .vram_we     (vram_we),
    .vram_addr   (vram_addr),
    .vram_wdata  (vram_wdata),
    .vram_gnt    (vram_gnt),
    .vram_rdata  (vram_rdata),
    .cram_we     (cram_we),
    .cram_addr   (cram_addr),
    .cram_wdata  (cram_wdata),
    .reg_we      (reg_we),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata)
`ifdef VDP_ACCESS_OVERRUN_EN
    ,
    .overrun     (overrun)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (vram_req) req_cycles <= req_cycles + 1;
    if (reg_we)   reg_pulses <= reg_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic cpu_wr(input logic sel, input logic [7:0] d);
    cpu_port_sel = sel;
    cpu_wdata    = d;
    cpu_wr_stb   = 1'b1;
    @(negedge clk);
    cpu_wr_stb   = 1'b0;
  endtask

  task automatic cpu_rd(input logic sel);
    cpu_port_sel = sel;
    cpu_rd_stb   = 1'b1;
    @(negedge clk);
    cpu_rd_stb   = 1'b0;
  endtask

  // Arbiter stand-in: wait for a request, stall 'delay' cycles, then grant once.
  task automatic serve(input int delay, input logic exp_we, input logic [13:0] exp_addr,
                       input logic [7:0] exp_wdata, input logic [7:0] rdata);
    int n = 0;
    while (!vram_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", vram_req, 1);
    check("req_wait", cpu_wait, 1);
    check("req_we", vram_we, exp_we);
    check("req_addr", vram_addr, exp_addr);
    if (exp_we) check("req_wdata", vram_wdata, exp_wdata);
    repeat (delay) begin
      @(negedge clk);
      check("stall_wait", cpu_wait, 1);
      check("stall_req", vram_req, 1);
    end
    vram_gnt   = 1'b1;
    vram_rdata = rdata;
    @(negedge clk);
    vram_gnt   = 1'b0;
  endtask

  initial begin
    reset_L      = 1'b0;
    cpu_wr_stb   = 1'b0;
    cpu_rd_stb   = 1'b0;
    cpu_port_sel = 1'b0;
    cpu_wdata    = 8'h00;
    vram_gnt     = 1'b0;
    vram_rdata   = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_wait", cpu_wait, 0);
    check("rst_req", vram_req, 0);
    check("rst_addr", vram_addr, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_cram_we", cram_we, 0);
    reset_L = 1'b1;
    @(negedge clk);

    // Register write: 0x34 then code 2, index 2.
    cpu_wr(1'b1, 8'h34);
    check("reg_first_nop", reg_we, 0);
    cpu_wr(1'b1, 8'h82);
    check("reg_we", reg_we, 1);
    check("reg_addr", reg_addr, 4'h2);
    check("reg_wdata", reg_wdata, 8'h34);
    check("reg_nowait", cpu_wait, 0);
    @(negedge clk);
    check("reg_we_drop", reg_we, 0);
    check("reg_pulses", reg_pulses, 1);
    check("reg_no_req", req_cycles, 0);
    check("reg_addr_upd", vram_addr, 14'h0234);

    // VRAM writes at 0x0000 with 3-cycle grant latency.
    cpu_wr(1'b1, 8'h00);
    cpu_wr(1'b1, 8'h40);
    check("wr_setup_noreq", vram_req, 0);
    cpu_wr(1'b0, 8'hAA);
    serve(3, 1'b1, 14'h0000, 8'hAA, 8'h00);
    check("wr1_done_wait", cpu_wait, 0);
    check("wr1_addr", vram_addr, 14'h0001);
    check("wr1_rdbuf", cpu_rdata, 8'hAA);
    cpu_wr(1'b0, 8'hBB);
    serve(3, 1'b1, 14'h0001, 8'hBB, 8'h00);
    check("wr2_addr", vram_addr, 14'h0002);

    // Read prefetch from 0x0010.
    cpu_wr(1'b1, 8'h10);
    cpu_wr(1'b1, 8'h00);
    serve(0, 1'b0, 14'h0010, 8'h00, 8'h5C);
    check("rd_data_wait", cpu_wait, 1);
    @(negedge clk);
    check("pf_rdbuf", cpu_rdata, 8'h5C);
    check("pf_addr", vram_addr, 14'h0011);
    check("pf_idle", cpu_wait, 0);
    check("rd1_value", cpu_rdata, 8'h5C);
    cpu_rd(1'b0);
    serve(1, 1'b0, 14'h0011, 8'h00, 8'h7E);
    @(negedge clk);
    check("rd2_value", cpu_rdata, 8'h7E);
    check("rd2_addr", vram_addr, 14'h0012);
    cpu_rd(1'b0);
    serve(0, 1'b0, 14'h0012, 8'h00, 8'h00);
    @(negedge clk);
    check("rd3_addr", vram_addr, 14'h0013);

    // CRAM writes across the 5-bit boundary.
    req_mark = req_cycles;
    cpu_wr(1'b1, 8'h1F);
    cpu_wr(1'b1, 8'hC0);
    cpu_wr(1'b0, 8'h3F);
    check("cram1_we", cram_we, 1);
    check("cram1_addr", cram_addr, 5'd31);
    check("cram1_data", cram_wdata, 8'h3F);
    check("cram1_nowait", cpu_wait, 0);
    check("cram1_rdbuf", cpu_rdata, 8'h3F);
    cpu_wr(1'b0, 8'h01);
    check("cram2_we", cram_we, 1);
    check("cram2_addr", cram_addr, 5'd0);
    check("cram2_data", cram_wdata, 8'h01);
    check("cram2_vaddr", vram_addr, 14'h0021);
    @(negedge clk);
    check("cram_we_drop", cram_we, 0);
    check("cram_no_req", req_cycles, req_mark);

    // Address wrap at 0x3FFF.
    cpu_wr(1'b1, 8'hFF);
    cpu_wr(1'b1, 8'h7F);
    cpu_wr(1'b0, 8'h55);
    serve(0, 1'b1, 14'h3FFF, 8'h55, 8'h00);
    check("wrap_addr", vram_addr, 14'h0000);

    // Status read discards a pending first byte.
    cpu_wr(1'b1, 8'h12);
    cpu_rd(1'b1);
    cpu_wr(1'b1, 8'h34);
    check("status_noreq", vram_req, 0);
    check("status_nowait", cpu_wait, 0);
    check("status_addr", vram_addr, 14'h0034);
    cpu_wr(1'b1, 8'h00);
    check("status_rd_req", vram_req, 1);
    check("status_rd_addr", vram_addr, 14'h0034);

    // Reset while RD_REQ is pending with a grant on the bus.
    vram_gnt = 1'b1;
    #2 reset_L = 1'b0;
    #1;
    check("rst_mid_req", vram_req, 0);
    check("rst_mid_wait", cpu_wait, 0);
    @(negedge clk);
    vram_gnt = 1'b0;
    reset_L  = 1'b1;
    @(negedge clk);
    check("rst2_rdata", cpu_rdata, 0);
    check("rst2_addr", vram_addr, 0);
    check("rst2_wait", cpu_wait, 0);
    check("rst2_req", vram_req, 0);

    // Strobe during a stall is dropped.
    cpu_wr(1'b1, 8'h00);
    cpu_wr(1'b1, 8'h40);
    cpu_wr(1'b0, 8'h66);
    cpu_wr(1'b0, 8'h77);
    check("drop_wdata", vram_wdata, 8'h66);
    check("drop_addr", vram_addr, 14'h0000);
`ifdef VDP_ACCESS_OVERRUN_EN
    check("overrun_set", overrun, 1);
`endif
    serve(0, 1'b1, 14'h0000, 8'h66, 8'h00);
    check("drop_addr_after", vram_addr, 14'h0001);
    check("drop_rdbuf", cpu_rdata, 8'h66);
`ifdef VDP_ACCESS_OVERRUN_EN
    check("overrun_sticky", overrun, 1);
    cpu_rd(1'b1);
    check("overrun_clear", overrun, 0);
`endif

    // Coincident write and read strobes: the write is taken.
    cpu_port_sel = 1'b0;
    cpu_wdata    = 8'h99;
    cpu_wr_stb   = 1'b1;
    cpu_rd_stb   = 1'b1;
    @(negedge clk);
    cpu_wr_stb   = 1'b0;
    cpu_rd_stb   = 1'b0;
    serve(0, 1'b1, 14'h0001, 8'h99, 8'h00);
    check("both_addr", vram_addr, 14'h0002);
    check("both_rdbuf", cpu_rdata, 8'h99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
